// File: rtl/riscv_pkg.sv
// Shared definitions for the pipelined RISC-V core: widths, the canonical NOP,
// and the IF/ID pipeline bundle with its bubble value.
package riscv_pkg;

   localparam int XLEN = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic            valid;
   } if_id_t;

   localparam if_id_t IF_ID_BUBBLE = '{
      instr:    NOP_INSTR,
      pc:       '0,
      pc_plus4: '0,
      valid:    1'b0
   };

endpackage

// File: rtl/pipe_reg.sv
// Parameterised pipeline register: async active-low reset to RESET_VAL,
// synchronous clear to CLR_VAL which wins over the load enable.
module pipe_reg #(
   parameter int           W         = 32,
   parameter logic [W-1:0] RESET_VAL = '0,
   parameter logic [W-1:0] CLR_VAL   = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] data_d;
   logic [W-1:0] data_q;

   always_comb begin
      data_d = data_q;
      if (clr) begin
         data_d = CLR_VAL;
      end else if (en) begin
         data_d = d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= RESET_VAL;
      end else begin
         data_q <= data_d;
      end
   end

   assign q = data_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register with redirect/stall, instruction-memory
// address, and the IF/ID pipeline register with stall and flush control.
module if_stage #(
   parameter int                   XLEN     = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0]      RESET_PC = riscv_pkg::RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            PCSrc,
   input  logic [XLEN-1:0] PCTarget,
   input  logic            stallF,
   input  logic            stallD,
   input  logic            flushD,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     InstrD,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PCPlus4D,
   output logic            ValidD,
   output logic            MisalignF
);

   import riscv_pkg::*;

   logic [XLEN-1:0] pcf;
   logic [XLEN-1:0] pcf_plus4;
   logic [XLEN-1:0] pc_next;
   logic            pc_en;
   logic            flush_eff;
   if_id_t          if_id_d;
   if_id_t          if_id_q;
   logic            misalign_d;
   logic            misalign_q;

   always_comb begin
      pcf_plus4  = pcf + XLEN'(4);
      // A redirect overrides stallF so a taken branch is never lost; its
      // low two bits are dropped and only reported through MisalignF.
      pc_next    = PCSrc ? {PCTarget[XLEN-1:2], 2'b00} : pcf_plus4;
      pc_en      = PCSrc | ~stallF;
      flush_eff  = flushD | PCSrc;
      misalign_d = PCSrc & (PCTarget[1:0] != 2'b00);

      if_id_d          = IF_ID_BUBBLE;
      if_id_d.instr    = imem_rdata;
      if_id_d.pc       = pcf;
      if_id_d.pc_plus4 = pcf_plus4;
      if_id_d.valid    = 1'b1;
   end

   pipe_reg #(
      .W         (XLEN),
      .RESET_VAL (RESET_PC),
      .CLR_VAL   (RESET_PC)
   ) u_pc_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (1'b0),
      .en    (pc_en),
      .d     (pc_next),
      .q     (pcf)
   );

   pipe_reg #(
      .W         ($bits(if_id_t)),
      .RESET_VAL (IF_ID_BUBBLE),
      .CLR_VAL   (IF_ID_BUBBLE)
   ) u_if_id_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush_eff),
      .en    (~stallD),
      .d     (if_id_d),
      .q     (if_id_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end

   assign imem_addr = pcf;
   assign InstrD    = if_id_q.instr;
   assign PCD       = if_id_q.pc;
   assign PCPlus4D  = if_id_q.pc_plus4;
   assign ValidD    = if_id_q.valid;
   assign MisalignF = misalign_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a main instance at RESET_PC=0x100 and a second
// instance at RESET_PC=0xFFFF_FFF8 for PC wrap-around.
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        pc_src;
   logic [31:0] pc_target;
   logic        stall_f;
   logic        stall_d;
   logic        flush_d;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc_plus4_d;
   logic        valid_d;
   logic        misalign_f;

   logic        rst2_n;
   logic [31:0] imem_addr2;
   logic [31:0] imem_rdata2;
   logic [31:0] instr_d2;
   logic [31:0] pc_d2;
   logic [31:0] pc_plus4_d2;
   logic        valid_d2;
   logic        misalign_f2;

   int n_checks;
   int n_pass;

   // Instruction memory model: each word is the bitwise inverse of its address.
   assign imem_rdata  = ~imem_addr;
   assign imem_rdata2 = ~imem_addr2;

   if_stage #(.XLEN(32), .RESET_PC(32'h0000_0100)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .PCSrc      (pc_src),
      .PCTarget   (pc_target),
      .stallF     (stall_f),
      .stallD     (stall_d),
      .flushD     (flush_d),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .InstrD     (instr_d),
      .PCD        (pc_d),
      .PCPlus4D   (pc_plus4_d),
      .ValidD     (valid_d),
      .MisalignF  (misalign_f)
   );

   if_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk        (clk),
      .rst_n      (rst2_n),
      .PCSrc      (1'b0),
      .PCTarget   (32'h0),
      .stallF     (1'b0),
      .stallD     (1'b0),
      .flushD     (1'b0),
      .imem_addr  (imem_addr2),
      .imem_rdata (imem_rdata2),
      .InstrD     (instr_d2),
      .PCD        (pc_d2),
      .PCPlus4D   (pc_plus4_d2),
      .ValidD     (valid_d2),
      .MisalignF  (misalign_f2)
   );

   // Clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_id(input string tag, input logic [31:0] pc, input logic [31:0] addr_next);
      check({tag, ".imem_addr"}, imem_addr, addr_next);
      check({tag, ".InstrD"},    instr_d,   ~pc);
      check({tag, ".PCD"},       pc_d,      pc);
      check({tag, ".PCPlus4D"},  pc_plus4_d, pc + 32'd4);
      check({tag, ".ValidD"},    {31'd0, valid_d}, 32'd1);
   endtask

   task automatic check_bubble(input string tag);
      check({tag, ".InstrD"},   instr_d,    NOP);
      check({tag, ".PCD"},      pc_d,       32'd0);
      check({tag, ".PCPlus4D"}, pc_plus4_d, 32'd0);
      check({tag, ".ValidD"},   {31'd0, valid_d}, 32'd0);
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      rst_n     = 1'b0;
      rst2_n    = 1'b0;
      pc_src    = 1'b0;
      pc_target = 32'd0;
      stall_f   = 1'b0;
      stall_d   = 1'b0;
      flush_d   = 1'b0;

      // Reset state
      #12;
      check("rst.imem_addr", imem_addr, 32'h100);
      check("rst.misalign", {31'd0, misalign_f}, 32'd0);
      check_bubble("rst");
      check("rst2.imem_addr", imem_addr2, 32'hFFFF_FFF8);

      // Release at the falling edge (t=20), away from the rising edge.
      @(negedge clk);
      rst_n = 1'b1;

      // Sequential fetch
      step(); check_id("seq0", 32'h100, 32'h104);
      step(); check_id("seq1", 32'h104, 32'h108);
      step(); check_id("seq2", 32'h108, 32'h10C);
      step(); check_id("seq3", 32'h10C, 32'h110);

      // Redirect to 0x200 at PCF=0x110
      pc_src = 1'b1; pc_target = 32'h200;
      step();
      check("redir.imem_addr", imem_addr, 32'h200);
      check("redir.misalign", {31'd0, misalign_f}, 32'd0);
      check_bubble("redir");
      pc_src = 1'b0;
      step(); check_id("redir_tgt", 32'h200, 32'h204);

      // Steer to 0x11C so PCF=0x120 with a real instruction in IF/ID
      pc_src = 1'b1; pc_target = 32'h11C;
      step();
      pc_src = 1'b0;
      step(); check_id("pre_stall", 32'h11C, 32'h120);

      // Combined stall for 3 cycles
      stall_f = 1'b1; stall_d = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(); check_id("stall", 32'h11C, 32'h120);
      end
      stall_f = 1'b0; stall_d = 1'b0;
      step(); check_id("unstall", 32'h120, 32'h124);

      // Misaligned redirect together with both stalls
      pc_src = 1'b1; pc_target = 32'h303; stall_f = 1'b1; stall_d = 1'b1;
      step();
      check("mis.imem_addr", imem_addr, 32'h300);
      check("mis.misalign", {31'd0, misalign_f}, 32'd1);
      check_bubble("mis");
      pc_src = 1'b0; stall_f = 1'b0; stall_d = 1'b0;
      step();
      check("mis_end.misalign", {31'd0, misalign_f}, 32'd0);
      check_id("mis_end", 32'h300, 32'h304);

      // flushD alone, then flushD overriding stallD
      flush_d = 1'b1;
      step();
      check("flush.imem_addr", imem_addr, 32'h308);
      check_bubble("flush");
      stall_d = 1'b1;
      step();
      check("flush_stall.imem_addr", imem_addr, 32'h30C);
      check_bubble("flush_stall");
      flush_d = 1'b0; stall_d = 1'b0;
      step(); check_id("post_flush", 32'h30C, 32'h310);

      // Mid-stream async reset while MisalignF is high
      pc_src = 1'b1; pc_target = 32'h402;
      step();
      pc_src = 1'b0;
      check("pre_arst.misalign", {31'd0, misalign_f}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst.imem_addr", imem_addr, 32'h100);
      check("arst.misalign", {31'd0, misalign_f}, 32'd0);
      check_bubble("arst");
      @(negedge clk);
      rst_n = 1'b1;
      step(); check_id("restart0", 32'h100, 32'h104);
      step(); check_id("restart1", 32'h104, 32'h108);

      // PC wrap-around on the second instance
      @(negedge clk);
      rst2_n = 1'b1;
      step();
      check("wrap0.imem_addr", imem_addr2, 32'hFFFF_FFFC);
      check("wrap0.PCD", pc_d2, 32'hFFFF_FFF8);
      check("wrap0.PCPlus4D", pc_plus4_d2, 32'hFFFF_FFFC);
      step();
      check("wrap1.imem_addr", imem_addr2, 32'h0000_0000);
      check("wrap1.PCD", pc_d2, 32'hFFFF_FFFC);
      check("wrap1.PCPlus4D", pc_plus4_d2, 32'h0000_0000);
      check("wrap1.InstrD", instr_d2, 32'h0000_0003);
      step();
      check("wrap2.imem_addr", imem_addr2, 32'h0000_0004);
      check("wrap2.PCD", pc_d2, 32'h0000_0000);
      check("wrap2.ValidD", {31'd0, valid_d2}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined RISC-V core: holds the program counter, advances it by 4 each cycle or redirects it to a branch/jump target when the branch-resolution logic asserts `PCSrc`, and drives the instruction-memory address. Registers the fetched instruction into the IF/ID pipeline register with stall and flush control from the hazard unit. It sits directly downstream of the PC-source selector in EX and upstream of decode.

## Interface
- `XLEN`, 32, address/PC width
- `RESET_PC`, 32'h0000_0000, PC value after reset
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `PCSrc`  in  1  redirect request from EX (taken branch or jump)
- `PCTarget`  in  XLEN  redirect target from EX
- `stallF`  in  1  hold PC (hazard unit)
- `stallD`  in  1  hold IF/ID register (hazard unit)
- `flushD`  in  1  clear IF/ID register to bubble (hazard unit)
- `imem_addr`  out  XLEN  instruction-memory address (= PCF)
- `imem_rdata`  in  32  instruction word, combinational read of `imem_addr`
- `InstrD`  out  32  IF/ID instruction
- `PCD`  out  XLEN  IF/ID PC of `InstrD`
- `PCPlus4D`  out  XLEN  IF/ID PC+4
- `ValidD`  out  1  IF/ID holds a real instruction
- `MisalignF`  out  1  registered one-cycle pulse: last accepted redirect had `PCTarget[1:0] != 0`

## Operation
- PC register update priority, highest first: `PCSrc` → PCF ← {PCTarget[XLEN-1:2], 2'b00}; else `!stallF` → PCF ← PCF + 4; else hold.
- `PCSrc` overrides `stallF`; a redirect is never lost.
- PC+4 is modulo 2^XLEN: 0xFFFF_FFFC + 4 → 0x0000_0000, no error.
- Effective flush = `flushD | PCSrc` (wrong-path instruction in IF is always killed on redirect, independent of the hazard unit).
- IF/ID update priority: effective flush → bubble; else `!stallD` → capture {imem_rdata, PCF, PCF+4, ValidD=1}; else hold all four fields.
- Bubble: `InstrD` = NOP (32'h0000_0013), `PCD` = 0, `PCPlus4D` = 0, `ValidD` = 0.
- Flush overrides `stallD`.
- `MisalignF` ← `PCSrc & (PCTarget[1:0] != 0)` every cycle; low bits are discarded, no trap raised here.
- `imem_addr` is combinational from PCF only (no path from `PCSrc` or `PCTarget`).

## Timing
- Reset (asynchronous, immediate on `rst_n` low, also mid-operation): PCF = `RESET_PC`, IF/ID = bubble, `MisalignF` = 0.
- First edge after `rst_n` rises: IF/ID captures instruction at `RESET_PC`, `ValidD` = 1; PCF = `RESET_PC`+4.
- Fetch latency: instruction at PCF appears on `InstrD` one edge later.
- Redirect: `PCSrc` high in cycle n → `imem_addr` = target in cycle n+1; that instruction on `InstrD` in cycle n+2; `InstrD` in cycle n+1 is a bubble (one-cycle penalty in IF plus whatever decode flush the hazard unit applies).
- `stallF` and `stallD` high together for k cycles: PCF and IF/ID unchanged for k edges, resume on edge k+1.
- `stallF` low, `stallD` high: permitted but the instruction at the skipped PC is dropped; the hazard unit is responsible for not doing this.
- Simultaneous `PCSrc` + `stallF` + `stallD`: PC redirects, IF/ID becomes bubble.

## Structure
- Shared package `riscv_pkg`: `XLEN`, `NOP_INSTR` (32'h0000_0013), default `RESET_PC`, IF/ID bundle struct (instr, pc, pc_plus4, valid).
- One sub-module: `pipe_reg`, a parameterised-width register with async active-low reset to a reset value, synchronous clear (to clear value) taking priority over enable. Instantiated once for PC and once for IF/ID.
- PC+4 adder and next-PC mux are inline in `if_stage`.

## Test plan
- Reset with `RESET_PC`=0x100, release, no stalls, imem returns addr-derived words: `imem_addr` 0x100, 0x104, 0x108...; `PCD` trails by one cycle, `ValidD` 1 from first edge.
- `PCSrc`=1, `PCTarget`=0x200 for one cycle at PCF=0x110: next `imem_addr`=0x200, `InstrD`=0x00000013/`ValidD`=0 next cycle, then instruction at 0x200 with `PCD`=0x200.
- `stallF`=`stallD`=1 for 3 cycles at PCF=0x120: `imem_addr` and all IF/ID outputs constant for 3 cycles, then 0x124 fetched.
- `PCSrc`=1 with `stallF`=`stallD`=1, `PCTarget`=0x303: PCF=0x300, IF/ID bubble, `MisalignF` pulses 1 for exactly one cycle.
- Start at `RESET_PC`=0xFFFF_FFF8: PC sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, `PCPlus4D` for 0xFFFF_FFFC = 0.
- `rst_n` asserted mid-stream between edges: outputs go to reset values immediately, before next `clk` edge; fetch restarts at `RESET_PC`.
